// File: rtl/lcd_nibble_tx.sv
// lcd_nibble_tx - byte-to-nibble transmitter for a 4-bit HD44780 LCD bus.
//
// A byte is accepted on a valid/ready handshake. It goes out as a high nibble
// and then a low nibble on data[3:0] (LCD DB7..DB4). Each nibble gets an
// enable pulse of EN_CYCLES and a settle gap of GAP_CYCLES. Clear/home
// commands (rs=0, byte 0x01..0x03) are followed by LONG_CYCLES of extra wait.
//
// Optional build macro: LCD_INIT_SEQ_EN
//   Defined   : after reset the block waits POWERUP_CYCLES. It then plays the
//               4-bit init sequence before accepting user bytes.
//   Undefined : the block is ready right after reset; init_done is tied high.
//
// State      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | waiting for a byte, in_ready high
// HI_EN      | en high, data = high nibble
// HI_GAP     | en low, high nibble held for settle
// LO_EN      | en high, data = low nibble
// LO_GAP     | en low, low nibble held for settle
// LONG_WAIT  | extra idle after a slow command (clear/home)
// PWR_WAIT   | power-up delay before init (macro only)
// INIT       | picks the next init nibble/byte (macro only)

module lcd_nibble_tx #(
  parameter int unsigned EN_CYCLES      = 800,
  parameter int unsigned GAP_CYCLES     = 800,
  parameter int unsigned LONG_CYCLES    = 60000,
  parameter int unsigned POWERUP_CYCLES = 600000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_byte,
  output logic       rs,
  output logic       en,
  output logic [3:0] data,
  output logic       busy,
  output logic       init_done
);

  // Counter reload values. The counter is loaded with N-1 on entry, and the
  // state advances on the edge where it reads zero, so each phase is N cycles.
  localparam logic [23:0] EN_LOAD   = 24'(EN_CYCLES - 1);
  localparam logic [23:0] GAP_LOAD  = 24'(GAP_CYCLES - 1);
  localparam logic [23:0] LONG_LOAD = 24'(LONG_CYCLES - 1);
  localparam logic [23:0] PWR_LOAD  = 24'(POWERUP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI_EN,
    S_HI_GAP,
    S_LO_EN,
    S_LO_GAP,
    S_LONG_WAIT
`ifdef LCD_INIT_SEQ_EN
    ,
    S_PWR_WAIT,
    S_INIT
`endif
  } state_t;

  state_t      state;
  logic [23:0] cnt;
  logic [7:0]  byte_q;
  logic        cnt_zero;
  logic        slow_cmd;

  assign cnt_zero = (cnt == 24'd0);

  // Clear display (0x01) and return home (0x02/0x03) need the long settle.
  assign slow_cmd = !rs && (byte_q[7:2] == 6'd0) && (byte_q[1:0] != 2'd0);

`ifdef LCD_INIT_SEQ_EN
  logic [3:0] init_idx;
  logic       single_q;

  // Byte part of the init sequence: function set 4-bit/2-line, display on,
  // entry mode increment, clear.
  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h28;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  endfunction
`else
  assign init_done = 1'b1;
`endif

  // Main sequencer: state, phase counter and all registered LCD outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= PWR_LOAD;
      byte_q <= 8'h00;
      rs     <= 1'b0;
      en     <= 1'b0;
      data   <= 4'h0;
      busy   <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
      state     <= S_PWR_WAIT;
      in_ready  <= 1'b0;
      init_done <= 1'b0;
      init_idx  <= 4'd0;
      single_q  <= 1'b0;
`else
      state    <= S_IDLE;
      in_ready <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            byte_q   <= in_byte;
            rs       <= in_rs;
            data     <= in_byte[7:4];
            en       <= 1'b1;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            cnt      <= EN_LOAD;
            state    <= S_HI_EN;
          end
        end

        S_HI_EN: begin
          if (cnt_zero) begin
            en    <= 1'b0;
            cnt   <= GAP_LOAD;
            state <= S_HI_GAP;
          end else begin
            cnt <= cnt - 24'd1;
          end
        end

        S_HI_GAP: begin
          if (cnt_zero) begin
`ifdef LCD_INIT_SEQ_EN
            if (single_q) begin
              // Single init nibble done; only the first 0x3 needs the long wait.
              single_q <= 1'b0;
              if (init_idx == 4'd1) begin
                cnt   <= LONG_LOAD;
                state <= S_LONG_WAIT;
              end else begin
                state <= S_INIT;
              end
            end else begin
              data  <= byte_q[3:0];
              en    <= 1'b1;
              cnt   <= EN_LOAD;
              state <= S_LO_EN;
            end
`else
            data  <= byte_q[3:0];
            en    <= 1'b1;
            cnt   <= EN_LOAD;
            state <= S_LO_EN;
`endif
          end else begin
            cnt <= cnt - 24'd1;
          end
        end

        S_LO_EN: begin
          if (cnt_zero) begin
            en    <= 1'b0;
            cnt   <= GAP_LOAD;
            state <= S_LO_GAP;
          end else begin
            cnt <= cnt - 24'd1;
          end
        end

        S_LO_GAP: begin
          if (cnt_zero) begin
            if (slow_cmd) begin
              cnt   <= LONG_LOAD;
              state <= S_LONG_WAIT;
            end else begin
`ifdef LCD_INIT_SEQ_EN
              if (init_done) begin
                busy     <= 1'b0;
                in_ready <= 1'b1;
                state    <= S_IDLE;
              end else begin
                state <= S_INIT;
              end
`else
              busy     <= 1'b0;
              in_ready <= 1'b1;
              state    <= S_IDLE;
`endif
            end
          end else begin
            cnt <= cnt - 24'd1;
          end
        end

        S_LONG_WAIT: begin
          if (cnt_zero) begin
`ifdef LCD_INIT_SEQ_EN
            if (init_done) begin
              busy     <= 1'b0;
              in_ready <= 1'b1;
              state    <= S_IDLE;
            end else begin
              state <= S_INIT;
            end
`else
            busy     <= 1'b0;
            in_ready <= 1'b1;
            state    <= S_IDLE;
`endif
          end else begin
            cnt <= cnt - 24'd1;
          end
        end

`ifdef LCD_INIT_SEQ_EN
        S_PWR_WAIT: begin
          busy <= 1'b1;
          if (cnt_zero) begin
            state <= S_INIT;
          end else begin
            cnt <= cnt - 24'd1;
          end
        end

        S_INIT: begin
          busy <= 1'b1;
          if (init_idx < 4'd4) begin
            // Nibble-only steps: 0x3, 0x3, 0x3, then 0x2 to switch to 4-bit.
            rs       <= 1'b0;
            data     <= (init_idx == 4'd3) ? 4'h2 : 4'h3;
            en       <= 1'b1;
            single_q <= 1'b1;
            cnt      <= EN_LOAD;
            init_idx <= init_idx + 4'd1;
            state    <= S_HI_EN;
          end else if (init_idx < 4'd8) begin
            byte_q   <= init_byte(init_idx[1:0]);
            rs       <= 1'b0;
            data     <= init_byte(init_idx[1:0]) >> 4;
            en       <= 1'b1;
            single_q <= 1'b0;
            cnt      <= EN_LOAD;
            init_idx <= init_idx + 4'd1;
            state    <= S_HI_EN;
          end else begin
            init_done <= 1'b1;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
`endif

        default: begin
          en       <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_nibble_tx.sv
// tb_lcd_nibble_tx - directed bench for lcd_nibble_tx (default build).
// A per-cycle monitor collects en pulses (length, nibble, rs) and the low runs
// between them. Each scenario compares those records with hand-computed values.

module tb_lcd_nibble_tx;

  localparam int EN   = 4;
  localparam int GAP  = 3;
  localparam int LONG = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_byte;
  logic       rs;
  logic       en;
  logic [3:0] data;
  logic       busy;
  logic       init_done;

  lcd_nibble_tx #(
    .EN_CYCLES      (EN),
    .GAP_CYCLES     (GAP),
    .LONG_CYCLES    (LONG),
    .POWERUP_CYCLES (20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rs     (in_rs),
    .in_byte   (in_byte),
    .rs        (rs),
    .en        (en),
    .data      (data),
    .busy      (busy),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor state, touched only from the single stimulus process.
  int         q_len[$];
  int         q_data[$];
  int         q_rs[$];
  int         q_low[$];
  int         cur_len;
  logic [3:0] cur_data;
  logic       cur_rs;
  int         low_len;
  bit         have_low;
  bit         prev_en;
  int         busy_cnt;
  int         n_unstable = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    q_len.delete();
    q_data.delete();
    q_rs.delete();
    q_low.delete();
    have_low = 0;
    prev_en  = 0;
    low_len  = 0;
    busy_cnt = 0;
  endtask

  // Advance to the next falling edge and record what the outputs show.
  task automatic tick();
    @(negedge clk);
    if (en) begin
      if (!prev_en) begin
        if (have_low) q_low.push_back(low_len);
        cur_len  = 1;
        cur_data = data;
        cur_rs   = rs;
      end else begin
        cur_len++;
        if (data !== cur_data || rs !== cur_rs) n_unstable++;
      end
    end else begin
      if (prev_en) begin
        q_len.push_back(cur_len);
        q_data.push_back(int'(cur_data));
        q_rs.push_back(int'(cur_rs));
        low_len  = 1;
        have_low = 1;
      end else begin
        low_len++;
      end
    end
    if (busy) busy_cnt++;
    prev_en = en;
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n;
    n = 0;
    while (!in_ready && n < budget) begin
      tick();
      n++;
    end
    if (!in_ready) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Offer one byte and return right after the accepting edge.
  task automatic send(input string tag, input logic r, input logic [7:0] b);
    wait_ready(tag, 200);
    in_rs    = r;
    in_byte  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_en_after_accept"}, 32'(en), 32'd1);
    check({tag, "_ready_after_accept"}, 32'(in_ready), 32'd0);
  endtask

  task automatic check_pulse(input string tag, input int i, input int exp_data, input int exp_rs);
    check({tag, "_len"}, 32'(q_len[i]), 32'(EN));
    check({tag, "_data"}, 32'(q_data[i]), 32'(exp_data));
    check({tag, "_rs"}, 32'(q_rs[i]), 32'(exp_rs));
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_rs    = 1'b0;
    in_byte  = 8'h00;
    clear_mon();
    repeat (3) @(negedge clk);

    check("rst_en", 32'(en), 32'd0);
    check("rst_rs", 32'(rs), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_init_done", 32'(init_done), 32'd1);

    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // Character 'A' (0x41): nibbles 4 then 1, rs=1, busy 2*4+2*3 = 14.
    clear_mon();
    send("chr41", 1'b1, 8'h41);
    wait_ready("chr41_done", 100);
    check("chr41_npulse", 32'(q_len.size()), 32'd2);
    check_pulse("chr41_p0", 0, 4, 1);
    check_pulse("chr41_p1", 1, 1, 1);
    check("chr41_gap", 32'(q_low[0]), 32'(GAP));
    check("chr41_busy", 32'(busy_cnt), 32'd14);

    // Clear command (rs=0, 0x01): adds the long wait, 14 + 10 = 24.
    clear_mon();
    send("clr", 1'b0, 8'h01);
    wait_ready("clr_done", 100);
    check("clr_npulse", 32'(q_len.size()), 32'd2);
    check_pulse("clr_p0", 0, 0, 0);
    check_pulse("clr_p1", 1, 1, 0);
    check("clr_busy", 32'(busy_cnt), 32'd24);

    // Same byte as character data is not slow.
    clear_mon();
    send("chr01", 1'b1, 8'h01);
    wait_ready("chr01_done", 100);
    check("chr01_busy", 32'(busy_cnt), 32'd14);

    // Home (0x02) and 0x04 (entry mode, not slow) as commands.
    clear_mon();
    send("home", 1'b0, 8'h02);
    wait_ready("home_done", 100);
    check("home_busy", 32'(busy_cnt), 32'd24);
    clear_mon();
    send("cmd04", 1'b0, 8'h04);
    wait_ready("cmd04_done", 100);
    check("cmd04_busy", 32'(busy_cnt), 32'd14);

    // Back-to-back with in_valid held: 0x48 then 0x49.
    clear_mon();
    wait_ready("b2b_start", 100);
    in_rs    = 1'b1;
    in_byte  = 8'h48;
    in_valid = 1'b1;
    tick();
    in_byte = 8'h49;
    begin
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
        tick();
        n++;
      end
      check("b2b_ready_seen", 32'(in_ready), 32'd1);
    end
    tick();
    in_valid = 1'b0;
    check("b2b_second_accept_en", 32'(en), 32'd1);
    check("b2b_second_accept_ready", 32'(in_ready), 32'd0);
    wait_ready("b2b_done", 100);
    check("b2b_npulse", 32'(q_len.size()), 32'd4);
    check_pulse("b2b_p0", 0, 4, 1);
    check_pulse("b2b_p1", 1, 8, 1);
    check_pulse("b2b_p2", 2, 4, 1);
    check_pulse("b2b_p3", 3, 9, 1);
    check("b2b_gap0", 32'(q_low[0]), 32'(GAP));
    check("b2b_gap1_ge", 32'(q_low[1] >= GAP), 32'd1);
    check("b2b_gap2", 32'(q_low[2]), 32'(GAP));

    // Reset in the second HI_EN cycle must drop en without a clock edge.
    clear_mon();
    send("rst_mid", 1'b1, 8'h55);
    tick();
    check("rst_mid_en_before", 32'(en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_en_async", 32'(en), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_data", 32'(data), 32'd0);
    check("rst_mid_rs", 32'(rs), 32'd0);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    tick();
    clear_mon();
    repeat (20) tick();
    check("rst_mid_no_pulse", 32'(q_len.size()), 32'd0);
    check("rst_mid_no_busy", 32'(busy_cnt), 32'd0);
    check("rst_mid_idle_ready", 32'(in_ready), 32'd1);

    // in_valid toggling while not ready is ignored.
    clear_mon();
    send("tog", 1'b1, 8'h37);
    in_byte = 8'hAA;
    begin
      int n;
      n = 0;
      while (n < 100) begin
        tick();
        n++;
        if (in_ready) break;
        in_valid = ~in_valid;
      end
      in_valid = 1'b0;
      check("tog_ready_back", 32'(in_ready), 32'd1);
    end
    repeat (10) tick();
    check("tog_npulse", 32'(q_len.size()), 32'd2);
    check_pulse("tog_p0", 0, 3, 1);
    check_pulse("tog_p1", 1, 7, 1);
    check("tog_busy", 32'(busy_cnt), 32'd14);

    check("data_rs_stable_while_en", 32'(n_unstable), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
